clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
// PURPOSE
//  Parametrised successor to the fixed single-output divider. NUM_CH independent
//  programmable dividers, each producing a 50% square wave (clkd) and a 1-cycle tick.
//  Divisor, enable and mode are CPU-programmable over the peripheral bus
//  (address/din/writeEnable/dout), in the same style as peripheral_controller.
//  Sits beside peripheral_controller as the timebase source for display
//  multiplexing, keypad scanning and software timers.
// PARAMETERS
//  NUM_CH       4          number of channels, 1..8
//  BASE_ADDR    32'hFF20   word address of channel 0 CTRL register
//  DEFAULT_DIV  24_999     DIV reset value for every channel
//  RESET_EN0    1          1: channel 0 enabled in toggle mode out of reset
// PORTS
//  clk          in   1         system clock (CLOCK_50)
//  reset        in   1         synchronous, active-high reset
//  address      in   32        bus word address
//  din          in   32        bus write data
//  writeEnable  in   1         write strobe, sampled on posedge clk
//  dout         out  32        read data, 1-cycle latency
//  clkd         out  NUM_CH    per-channel square-wave output
//  tick         out  NUM_CH    per-channel 1-cycle pulse at terminal count
// BEHAVIOUR
//  Register map (word addresses, ch = 0..NUM_CH-1):
//   BASE_ADDR+2*ch   CTRL  [0]=EN  [1]=MODE (0 periodic, 1 one-shot); other bits read 0
//   BASE_ADDR+2*ch+1 DIV   [31:0] terminal count
//   BASE_ADDR+2*NUM_CH  STAT [NUM_CH-1:0] sticky terminal-count flags, write-1-to-clear
//  Reset: all counters 0; clkd=0; tick=0; dout=0; STAT=0; DIV=DEFAULT_DIV;
//   CTRL=0, except CTRL0.EN=RESET_EN0 with MODE=0.
//  Writes with writeEnable=1 take effect on that clock edge; unmapped addresses ignored.
//  Reads: dout <= register at address on every edge (registered, 1 cycle); unmapped -> 0.
//  Per-channel counter ctr[31:0], when EN=1:
//   ctr<DIV: ctr<=ctr+1.  ctr>=DIV: terminal count (TC): ctr<=0, tick=1 for 1 cycle,
//   clkd<=~clkd, STAT[ch]<=1.  Period between ticks = DIV+1 clk cycles;
//   clkd period = 2*(DIV+1). DIV=0 -> tick every cycle, clkd = clk/2.
//  MODE=1 (one-shot): at first TC, tick/STAT/clkd behave as above, then EN is cleared
//   by hardware in the same edge; counter held at 0 afterwards.
//  EN=0: ctr held at 0, tick=0, clkd holds its last level (no glitch on disable).
//  Writing CTRL with EN 0->1 or writing DIV: ctr<=0 on that edge (restart, no TC that cycle);
//   clkd is not altered by the write.
//  Writing DIV below current ctr: counter restarts (above), so no wrap past 2^32.
//  ctr >= DIV comparison is unsigned 32-bit; ctr never exceeds DIV after a write restart.
//  STAT: a TC and a write-1-to-clear on the same bit in the same cycle -> bit stays 1 (set wins).
//  Software CTRL write and one-shot hardware EN clear in the same cycle -> software write wins.
//  Channels are fully independent; simultaneous TCs on several channels are all recorded.
//  reset asserted mid-count: all state returns to reset values on that edge; outputs
//   valid reset values from the following cycle.
// TESTING
//  1 Reset, RESET_EN0=1, DIV=24_999: first tick[0] at cycle 25_000 after reset release;
//    clkd[0] toggles every 25_000 cycles; other channels idle at 0.
//  2 Write DIV1=3, CTRL1=1: tick[1] every 4 cycles, clkd[1] period 8; read STAT -> bit1=1;
//    write STAT=2 -> bit1 clears unless TC in same cycle.
//  3 CTRL2=3 (one-shot), DIV2=9: exactly one tick[2] 10 cycles after write; CTRL2 reads 2.
//  4 DIV3=0, EN: tick[3] high every cycle, clkd[3]=clk/2; then EN=0 -> tick 0, clkd holds.
//  5 Channel 1 counting at ctr=50, DIV1=100: write DIV1=10 -> next TC 11 cycles later.
//  6 Assert reset mid-count on all channels -> all outputs, STAT, dout = 0, DIV=DEFAULT_DIV
//    next cycle; read of unmapped address BASE_ADDR+2*NUM_CH+1 -> dout=0.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable dividers, each producing a 50% clkd and a 1-cycle tick.
// CTRL/DIV per channel plus a shared sticky STAT register on the word-addressed bus.

package clock_divider_bank_pkg;

    typedef struct packed {
        logic        ctrl_we;
        logic        div_we;
        logic [31:0] wdata;
    } ch_req_t;

    typedef struct packed {
        logic        en;
        logic        mode;
        logic [31:0] div;
        logic        tc;
    } ch_rsp_t;

endpackage

module clock_divider_ch
    import clock_divider_bank_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DIV = 32'd24_999,
    parameter bit          RESET_EN    = 1'b0
) (
    input  logic    clk,
    input  logic    reset,
    input  ch_req_t req,
    output ch_rsp_t rsp,
    output logic    tick,
    output logic    clkd
);

    logic [31:0] ctr;
    logic [31:0] div;
    logic        en;
    logic        mode;
    logic        restart;
    logic        tc;
    logic        en_next;

    always_comb begin
        // DIV writes and EN 0->1 restart the count and suppress TC on that edge
        restart = req.div_we || (req.ctrl_we && req.wdata[0] && !en);
        tc      = en && (ctr >= div) && !restart;
        en_next = en;
        if (req.ctrl_we)
            en_next = req.wdata[0];
        else if (tc && mode)
            en_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr  <= '0;
            div  <= DEFAULT_DIV;
            en   <= RESET_EN;
            mode <= 1'b0;
            tick <= 1'b0;
            clkd <= 1'b0;
        end else begin
            tick <= tc;
            en   <= en_next;
            if (tc)
                clkd <= ~clkd;
            if (req.ctrl_we)
                mode <= req.wdata[1];
            if (req.div_we)
                div <= req.wdata;
            if (restart || tc || !en_next)
                ctr <= '0;
            else
                ctr <= ctr + 32'd1;
        end
    end

    assign rsp = '{en: en, mode: mode, div: div, tc: tc};

endmodule

module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter logic [31:0] BASE_ADDR   = 32'hFF20,
    parameter logic [31:0] DEFAULT_DIV = 32'd24_999,
    parameter bit          RESET_EN0   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic [31:0]       din,
    input  logic              writeEnable,
    output logic [31:0]       dout,
    output logic [NUM_CH-1:0] clkd,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [31:0] STAT_OFF = 32'(2 * NUM_CH);

    // Addresses below BASE_ADDR wrap to a huge offset and decode as unmapped
    logic [31:0]       off;
    logic              stat_hit;
    logic [NUM_CH-1:0] tc_vec;
    logic [NUM_CH-1:0] stat;
    logic [NUM_CH-1:0] stat_clr;
    logic [31:0]       rdata;
    ch_req_t           req [NUM_CH];
    ch_rsp_t           rsp [NUM_CH];

    assign off      = address - BASE_ADDR;
    assign stat_hit = (off == STAT_OFF);
    assign stat_clr = (writeEnable && stat_hit) ? din[NUM_CH-1:0] : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign req[g].ctrl_we = writeEnable && (off == 32'(2 * g));
        assign req[g].div_we  = writeEnable && (off == 32'(2 * g + 1));
        assign req[g].wdata   = din;
        assign tc_vec[g]      = rsp[g].tc;

        clock_divider_ch #(
            .DEFAULT_DIV (DEFAULT_DIV),
            .RESET_EN    ((g == 0) ? RESET_EN0 : 1'b0)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .req   (req[g]),
            .rsp   (rsp[g]),
            .tick  (tick[g]),
            .clkd  (clkd[g])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == 32'(2 * i))
                rdata = {30'd0, rsp[i].mode, rsp[i].en};
            if (off == 32'(2 * i + 1))
                rdata = rsp[i].div;
        end
        if (stat_hit)
            rdata = 32'(stat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat <= '0;
            dout <= '0;
        end else begin
            // set wins over a same-cycle write-1-to-clear
            stat <= (stat & ~stat_clr) | tc_vec;
            dout <= rdata;
        end
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: stimulus queues expected tick/clkd/dout
// values per cycle, a negedge monitor pops and compares them.

module tb_clock_divider_bank;

    localparam int          NCH  = 4;
    localparam logic [31:0] BASE = 32'hFF20;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    address = '0;
    logic [31:0]    din = '0;
    logic           writeEnable = 1'b0;
    logic [31:0]    dout;
    logic [NCH-1:0] clkd;
    logic [NCH-1:0] tick;

    clock_divider_bank #(
        .NUM_CH      (NCH),
        .BASE_ADDR   (BASE),
        .DEFAULT_DIV (32'd24_999),
        .RESET_EN0   (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .din         (din),
        .writeEnable (writeEnable),
        .dout        (dout),
        .clkd        (clkd),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] mask;
        logic [31:0] exp;
        logic [63:0] nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input int c, input int sel, input logic [31:0] m,
                             input logic [31:0] e, input logic [63:0] nm);
        exp_t x;
        x.cyc = c; x.sel = sel; x.mask = m; x.exp = e; x.nm = nm;
        sb.push_back(x);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(tick);
            1:       return 32'(clkd);
            default: return dout;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act = observe(sb[i].sel) & sb[i].mask;
                n_cmp++;
                if (sb[i].cyc < cyc || act != (sb[i].exp & sb[i].mask)) begin
                    n_bad++;
                    $display("FAIL %0s @cyc %0d: got %h, want %h", sb[i].nm, sb[i].cyc,
                             act, sb[i].exp & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a; din = d; writeEnable = 1'b1;
        @(negedge clk);
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] m, input logic [31:0] e,
                      input logic [63:0] nm);
        address = a;
        expect_at(cyc + 1, 2, m, e, nm);
        @(negedge clk);
    endtask

    initial begin
        int c, e2, s3, s3b, s4, a, w, r0;

        @(negedge clk);
        expect_at(cyc + 1, 0, '1, 0, "rsttick");
        expect_at(cyc + 1, 1, '1, 0, "rstclkd");
        expect_at(cyc + 1, 2, '1, 0, "rstdout");
        wait_until(4);
        reset = 1'b0;
        c = cyc;

        expect_at(c + 1,     0, 32'h1, 0, "t1tick");
        expect_at(c + 24999, 0, 32'h1, 0, "t1tick");
        expect_at(c + 25000, 0, 32'h1, 1, "t1tick");
        expect_at(c + 25001, 0, 32'h1, 0, "t1tick");
        expect_at(c + 49999, 0, 32'h1, 0, "t1tick");
        expect_at(c + 50000, 0, 32'h1, 1, "t1tick");
        expect_at(c + 24999, 1, 32'h1, 0, "t1clkd");
        expect_at(c + 25000, 1, 32'h1, 1, "t1clkd");
        expect_at(c + 49999, 1, 32'h1, 1, "t1clkd");
        expect_at(c + 50000, 1, 32'h1, 0, "t1clkd");
        expect_at(c + 1,     0, 32'hE, 0, "idletick");
        expect_at(c + 1,     1, 32'hE, 0, "idleclkd");
        rd(BASE + 0, '1, 1,     "ctrl0");
        rd(BASE + 1, '1, 24999, "div0");
        rd(BASE + 2, '1, 0,     "ctrl1");

        wait_until(c + 10);
        wr(BASE + 3, 3);
        wr(BASE + 2, 1);
        e2 = cyc;
        for (int k = 1; k <= 12; k++)
            expect_at(e2 + k, 0, 32'h2, (k % 4 == 0) ? 32'h2 : 32'h0, "t2tick");
        expect_at(e2 + 3,  1, 32'h2, 0, "t2clkd");
        expect_at(e2 + 4,  1, 32'h2, 2, "t2clkd");
        expect_at(e2 + 7,  1, 32'h2, 2, "t2clkd");
        expect_at(e2 + 8,  1, 32'h2, 0, "t2clkd");
        expect_at(e2 + 12, 1, 32'h2, 2, "t2clkd");
        wait_until(e2 + 5);
        rd(BASE + 8, 32'h2, 2, "t2stat");
        wait_until(e2 + 8);
        wr(BASE + 8, 2);
        expect_at(e2 + 10, 2, 32'h2, 0, "t2clr");
        expect_at(e2 + 11, 2, 32'h2, 0, "t2clr");
        expect_at(e2 + 12, 2, 32'h2, 0, "t2clr");
        expect_at(e2 + 13, 2, 32'h2, 2, "t2reset");
        wait_until(e2 + 13);
        wr(BASE + 8, 2);
        expect_at(e2 + 15, 2, 32'h2, 0, "t2clr2");
        expect_at(e2 + 16, 2, 32'h2, 0, "t2clr2");
        expect_at(e2 + 17, 2, 32'h2, 2, "t2setwin");
        wait_until(e2 + 15);
        wr(BASE + 8, 2);

        wait_until(e2 + 20);
        wr(BASE + 5, 9);
        wr(BASE + 4, 3);
        s3 = cyc;
        for (int k = 1; k <= 19; k++)
            expect_at(s3 + k, 0, 32'h4, (k == 10) ? 32'h4 : 32'h0, "t3tick");
        expect_at(s3 + 9,  1, 32'h4, 0, "t3clkd");
        expect_at(s3 + 10, 1, 32'h4, 4, "t3clkd");
        expect_at(s3 + 19, 1, 32'h4, 4, "t3clkd");
        wait_until(s3 + 15);
        rd(BASE + 4, '1, 2, "t3ctrl");
        wait_until(s3 + 19);
        wr(BASE + 4, 3);
        s3b = cyc;
        for (int k = 1; k <= 25; k++)
            expect_at(s3b + k, 0, 32'h4, (k == 10 || k == 20) ? 32'h4 : 32'h0, "t3btick");
        expect_at(s3b + 9,  1, 32'h4, 4, "t3bclkd");
        expect_at(s3b + 10, 1, 32'h4, 0, "t3bclkd");
        expect_at(s3b + 19, 1, 32'h4, 0, "t3bclkd");
        expect_at(s3b + 20, 1, 32'h4, 4, "t3bclkd");
        expect_at(s3b + 25, 1, 32'h4, 4, "t3bclkd");
        wait_until(s3b + 9);
        wr(BASE + 4, 3);
        wait_until(s3b + 12);
        rd(BASE + 4, '1, 3, "t3swwin");
        wait_until(s3b + 22);
        rd(BASE + 4, '1, 2, "t3oneshot");

        wait_until(s3b + 30);
        wr(BASE + 7, 0);
        wr(BASE + 6, 1);
        s4 = cyc;
        for (int k = 1; k <= 10; k++) begin
            expect_at(s4 + k, 0, 32'h8, (k <= 5) ? 32'h8 : 32'h0, "t4tick");
            expect_at(s4 + k, 1, 32'h8, (k > 5 || (k % 2) == 1) ? 32'h8 : 32'h0, "t4clkd");
        end
        wait_until(s4 + 4);
        wr(BASE + 6, 0);

        wait_until(s4 + 15);
        wr(BASE + 3, 100);
        a = cyc;
        w = a + 51;
        for (int k = a + 1; k <= w + 22; k++)
            expect_at(k, 0, 32'h2, (k == w + 11 || k == w + 22) ? 32'h2 : 32'h0, "t5tick");
        wait_until(w - 1);
        wr(BASE + 3, 10);

        wait_until(c + 50002);
        address = BASE + 3;
        expect_at(cyc + 1, 1, 32'hC, 32'hC, "prerst");
        expect_at(cyc + 1, 2, '1, 10, "prerstdv");
        @(negedge clk);
        reset = 1'b1;
        r0 = cyc;
        expect_at(r0 + 1, 0, '1, 0, "t6tick");
        expect_at(r0 + 1, 1, '1, 0, "t6clkd");
        expect_at(r0 + 1, 2, '1, 0, "t6dout");
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (tick !== '0) begin
            n_bad++;
            $display("FAIL direct tick after reset: got %h", tick);
        end
        n_cmp++;
        if (clkd !== '0) begin
            n_bad++;
            $display("FAIL direct clkd after reset: got %h", clkd);
        end
        n_cmp++;
        if (dout !== 32'd0) begin
            n_bad++;
            $display("FAIL direct dout after reset: got %h", dout);
        end
        expect_at(r0 + 3, 0, '1, 0, "t6tick2");
        expect_at(r0 + 3, 1, '1, 0, "t6clkd2");
        rd(BASE + 3, '1, 24999, "t6div1");
        rd(BASE + 8, '1, 0,     "t6stat");
        rd(BASE + 9, '1, 0,     "unmap");
        rd(BASE + 2, '1, 0,     "t6ctrl1");
        rd(BASE + 0, '1, 1,     "t6ctrl0");

        wait_until(r0 + 8);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            n_bad++;
            $display("FAIL %0s never checked (cyc %0d)", sb[0].nm, sb[0].cyc);
            sb.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
